// File: rtl/ex_stage_if.sv
// ex_stage_if: decode-to-execute handshake and instruction payload bundle.
// Ports (signals):
//   ds_to_es_valid, ds_pc, ds_alu_op, ds_div_op, ds_alu_src1, ds_alu_src2,
//   ds_rkd_value, ds_res_from_mem, ds_mem_we, ds_rf_we, ds_rf_waddr : decode -> execute
//   es_allowin                                                       : execute -> decode
// Modports: master = decode side, slave = execute side.
interface ex_stage_if #(
    parameter int ALU_OP_W = 12,
    parameter int DIV_OP_W = 4
);
    logic                es_allowin;
    logic                ds_to_es_valid;
    logic [31:0]         ds_pc;
    logic [ALU_OP_W-1:0] ds_alu_op;
    logic [DIV_OP_W-1:0] ds_div_op;
    logic [31:0]         ds_alu_src1;
    logic [31:0]         ds_alu_src2;
    logic [31:0]         ds_rkd_value;
    logic                ds_res_from_mem;
    logic                ds_mem_we;
    logic                ds_rf_we;
    logic [4:0]          ds_rf_waddr;
    modport master (
        input  es_allowin,
        output ds_to_es_valid, ds_pc, ds_alu_op, ds_div_op, ds_alu_src1, ds_alu_src2,
               ds_rkd_value, ds_res_from_mem, ds_mem_we, ds_rf_we, ds_rf_waddr
    );
    modport slave (
        output es_allowin,
        input  ds_to_es_valid, ds_pc, ds_alu_op, ds_div_op, ds_alu_src1, ds_alu_src2,
               ds_rkd_value, ds_res_from_mem, ds_mem_we, ds_rf_we, ds_rf_waddr
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage with single-cycle ALU, 32-step radix-2 divider
// and data SRAM request issue.
// Ports:
//   clk, reset (async, active-high)
//   ms_allowin                : memory stage can accept
//   ds                        : decode handshake/payload bundle (slave side)
//   es_to_ms_valid, es_pc, es_alu_result, es_res_from_mem, es_rf_we, es_rf_waddr
//                             : result handed to memory stage / forwarded to decode
//   es_div_busy               : divider not idle
//   data_sram_en/we/addr/wdata: data SRAM request, issued in the transfer cycle
module ex_stage #(
    parameter int ALU_OP_W = 12,
    parameter int DIV_OP_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_allowin,
    ex_stage_if.slave   ds,
    output logic        es_to_ms_valid,
    output logic [31:0] es_pc,
    output logic [31:0] es_alu_result,
    output logic        es_res_from_mem,
    output logic        es_rf_we,
    output logic [4:0]  es_rf_waddr,
    output logic        es_div_busy,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
    logic                es_valid_q, ld_q, st_q, rf_we_q;
    logic [31:0]         pc_q, src1_q, src2_q, rkd_q;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic [DIV_OP_W-1:0] div_op_q;
    logic [4:0]          waddr_q;
    div_state_e          state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [31:0]         quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic                qneg_q, qneg_d, rneg_q, rneg_d;
    logic                is_div, es_ready_go, es_allowin, sgn, s1n, s2n, ge;
    logic [32:0]         trial, diff;
    logic [4:0]          sa;
    logic [31:0]         alu_res, div_res;
    assign is_div         = |div_op_q;
    assign es_ready_go    = !is_div || state_q == DONE;
    assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
    assign ds.es_allowin  = es_allowin;
    assign es_to_ms_valid = es_valid_q && es_ready_go;
    assign sa             = src2_q[4:0];
    assign alu_res = ({32{alu_op_q[0]}}  & (src1_q + src2_q))
                   | ({32{alu_op_q[1]}}  & (src1_q - src2_q))
                   | ({32{alu_op_q[2]}}  & {31'b0, $signed(src1_q) < $signed(src2_q)})
                   | ({32{alu_op_q[3]}}  & {31'b0, src1_q < src2_q})
                   | ({32{alu_op_q[4]}}  & (src1_q & src2_q))
                   | ({32{alu_op_q[5]}}  & ~(src1_q | src2_q))
                   | ({32{alu_op_q[6]}}  & (src1_q | src2_q))
                   | ({32{alu_op_q[7]}}  & (src1_q ^ src2_q))
                   | ({32{alu_op_q[8]}}  & (src1_q << sa))
                   | ({32{alu_op_q[9]}}  & (src1_q >> sa))
                   | ({32{alu_op_q[10]}} & 32'($signed(src1_q) >>> sa))
                   | ({32{alu_op_q[11]}} & src2_q);
    assign sgn   = div_op_q[0] | div_op_q[1];
    assign s1n   = sgn & src1_q[31];
    assign s2n   = sgn & src2_q[31];
    // Restoring step: quo_q shifts dividend bits out the top and quotient bits in at the bottom.
    assign trial = {rem_q, quo_q[31]};
    assign diff  = trial - {1'b0, dvs_q};
    assign ge    = trial >= {1'b0, dvs_q};
    assign div_res = (div_op_q[0] | div_op_q[2]) ? (qneg_q ? -quo_q : quo_q)
                                                 : (rneg_q ? -rem_q : rem_q);
    assign es_alu_result   = is_div ? div_res : alu_res;
    assign es_pc           = pc_q;
    assign es_res_from_mem = ld_q;
    assign es_rf_we        = es_valid_q & rf_we_q;
    assign es_rf_waddr     = waddr_q;
    assign es_div_busy     = state_q != IDLE;
    assign data_sram_en    = es_valid_q & es_ready_go & ms_allowin & (ld_q | st_q);
    assign data_sram_we    = {4{st_q & data_sram_en}};
    assign data_sram_addr  = es_alu_result;
    assign data_sram_wdata = rkd_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            IDLE: if (es_valid_q && is_div) begin
                state_d = BUSY;
                cnt_d   = 5'd0;
                quo_d   = s1n ? -src1_q : src1_q;
                dvs_d   = s2n ? -src2_q : src2_q;
                rem_d   = 32'd0;
                // A zero divisor must yield an all-ones quotient regardless of sign.
                qneg_d  = (s1n ^ s2n) && src2_q != 32'd0;
                rneg_d  = s1n;
            end
            BUSY: begin
                rem_d   = ge ? diff[31:0] : trial[31:0];
                quo_d   = {quo_q[30:0], ge};
                cnt_d   = cnt_q + 5'd1;
                state_d = cnt_q == 5'd31 ? DONE : BUSY;
            end
            DONE: state_d = (es_to_ms_valid && ms_allowin) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            pc_q       <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            rkd_q      <= '0;
            alu_op_q   <= '0;
            div_op_q   <= '0;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            rf_we_q    <= 1'b0;
            waddr_q    <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
        end else begin
            if (es_allowin) es_valid_q <= ds.ds_to_es_valid;
            if (es_allowin && ds.ds_to_es_valid) begin
                pc_q     <= ds.ds_pc;
                src1_q   <= ds.ds_alu_src1;
                src2_q   <= ds.ds_alu_src2;
                rkd_q    <= ds.ds_rkd_value;
                alu_op_q <= ds.ds_alu_op;
                div_op_q <= ds.ds_div_op;
                ld_q     <= ds.ds_res_from_mem;
                st_q     <= ds.ds_mem_we;
                rf_we_q  <= ds.ds_rf_we;
                waddr_q  <= ds.ds_rf_waddr;
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
endmodule
